// File: rtl/led_stretch_driver.sv
// rtl/led_stretch_driver.sv - stretches LED status pulses to a visible on-time with global PWM dimming
// Optional lamp-test override is enabled by defining LED_LAMP_TEST_EN.
module led_stretch_driver #(
    parameter int PRESCALE   = 100000,
    parameter int HOLD_TICKS = 50
) (
    input  logic       fpga_clk,
    input  logic       sys_init_ctrl_n,
    input  logic [3:0] led_in,
    input  logic [8:0] cover_led_in,
    input  logic [3:0] brightness,
    input  logic       lamp_test,
    output logic [3:0] led_out,
    output logic [8:0] cover_led_out
);

    localparam int NCH = 13;
    localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HW  = $clog2(HOLD_TICKS + 1);

    logic [PW-1:0]  presc_cnt;
    logic           tick;
    logic [3:0]     pwm_cnt;
    logic           pwm_on;
    logic           lamp_force;
    logic [NCH-1:0] chan_in;
    logic [NCH-1:0] act;
    logic [NCH-1:0] out_q;
    logic [HW-1:0]  hold_cnt [NCH];

    assign chan_in = {led_in, cover_led_in};
    assign tick    = (presc_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
        if (!sys_init_ctrl_n) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PW'(1);
        end
    end

    // Reload beats decrement, so an input seen in a tick cycle restarts the full hold.
    always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
        if (!sys_init_ctrl_n) begin
            for (int i = 0; i < NCH; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (chan_in[i]) begin
                    hold_cnt[i] <= HW'(HOLD_TICKS);
                end else if (tick && (hold_cnt[i] != '0)) begin
                    hold_cnt[i] <= hold_cnt[i] - HW'(1);
                end
            end
        end
    end

    always_comb begin
        act = '0;
        for (int i = 0; i < NCH; i++) begin
            act[i] = chan_in[i] | (hold_cnt[i] != '0);
        end
    end

    // PWM phase is set only by reset; it is deliberately not aligned to input events.
    always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
        if (!sys_init_ctrl_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    assign pwm_on = (brightness == 4'hf) | (pwm_cnt < brightness);

`ifdef LED_LAMP_TEST_EN
    assign lamp_force = lamp_test;
`else
    logic unused_lamp_test;
    assign unused_lamp_test = lamp_test;
    assign lamp_force       = 1'b0;
`endif

    always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
        if (!sys_init_ctrl_n) begin
            out_q <= '0;
        end else begin
            out_q <= {NCH{lamp_force}} | (act & {NCH{pwm_on}});
        end
    end

    assign led_out       = out_q[12:9];
    assign cover_led_out = out_q[8:0];

endmodule

// File: tb/tb_led_stretch_driver.sv
// tb/tb_led_stretch_driver.sv - self-checking bench for led_stretch_driver with PRESCALE=4, HOLD_TICKS=3
module tb_led_stretch_driver;

    localparam int P = 4;
    localparam int H = 3;

    logic       fpga_clk = 1'b0;
    logic       sys_init_ctrl_n;
    logic [3:0] led_in;
    logic [8:0] cover_led_in;
    logic [3:0] brightness;
    logic       lamp_test;
    logic [3:0] led_out;
    logic [8:0] cover_led_out;

    int checks = 0;
    int errors = 0;

    led_stretch_driver #(.PRESCALE(P), .HOLD_TICKS(H)) dut (
        .fpga_clk        (fpga_clk),
        .sys_init_ctrl_n (sys_init_ctrl_n),
        .led_in          (led_in),
        .cover_led_in    (cover_led_in),
        .brightness      (brightness),
        .lamp_test       (lamp_test),
        .led_out         (led_out),
        .cover_led_out   (cover_led_out)
    );

    always #5 fpga_clk = ~fpga_clk;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        checks++;
        if (v < lo || v > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, v, lo, hi);
        end
    endtask

    // Model: edge k (1-based after reset release) sees ticks on edges that are multiples of P;
    // a channel last seen high at edge j stays active while fewer than H ticks fell in (j, k-1].
    int          k_edge = 0;
    int          last_hi [13];
    bit          seen_hi [13];
    logic [12:0] exp_out = '0;

    always @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
        if (!sys_init_ctrl_n) begin
            k_edge  = 0;
            exp_out = '0;
            for (int i = 0; i < 13; i++) seen_hi[i] = 1'b0;
        end else begin
            logic [12:0] vin;
            bit          on;
            bit          a;
            int          ticks;
            k_edge++;
            vin = {led_in, cover_led_in};
            on  = (brightness == 4'd15) || (((k_edge - 1) % 16) < int'(brightness));
            for (int i = 0; i < 13; i++) begin
                ticks = seen_hi[i] ? ((k_edge - 1) / P - last_hi[i] / P) : 0;
                a     = vin[i] || (seen_hi[i] && ticks < H);
`ifdef LED_LAMP_TEST_EN
                exp_out[i] = lamp_test || (a && on);
`else
                exp_out[i] = a && on;
`endif
                if (vin[i]) begin
                    last_hi[i] = k_edge;
                    seen_hi[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge fpga_clk) begin
        check("model_compare", 32'({led_out, cover_led_out}), 32'(exp_out));
    end

    initial begin
        int cnt;
        int w [4];
        bit hi;
        logic [12:0] lamp_exp;

        sys_init_ctrl_n = 1'b0;
        led_in          = '0;
        cover_led_in    = '0;
        brightness      = 4'd15;
        lamp_test       = 1'b0;
        repeat (3) @(negedge fpga_clk);
        check("reset_state", 32'({led_out, cover_led_out}), 32'h0);
        sys_init_ctrl_n = 1'b1;
        repeat (5) @(negedge fpga_clk);

        // Single pulse on cover channel 4
        cover_led_in[4] = 1'b1;
        @(negedge fpga_clk);
        check("pulse_rise", 32'(cover_led_out[4]), 32'h1);
        cnt = int'(cover_led_out[4]);
        cover_led_in = '0;
        repeat (20) begin
            @(negedge fpga_clk);
            cnt += int'(cover_led_out[4]);
        end
        check_range("pulse_len", cnt, 10, 13);

        // Retrigger on front-panel channel 2
        led_in[2] = 1'b1;
        hi = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge fpga_clk);
            hi &= led_out[2];
            led_in[2] = (c == 6);
        end
        led_in = '0;
        check("retrigger_continuous", 32'(hi), 32'h1);
        repeat (20) @(negedge fpga_clk);

        // PWM duty at brightness 4
        brightness = 4'd4;
        led_in[0]  = 1'b1;
        for (int i = 0; i < 4; i++) w[i] = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge fpga_clk);
            w[c / 16] += int'(led_out[0]);
        end
        for (int i = 0; i < 4; i++) check($sformatf("pwm_window%0d", i), 32'(w[i]), 32'd4);
        check("pwm_total", 32'(w[0] + w[1] + w[2] + w[3]), 32'd16);
        brightness = 4'd0;
        cnt = 0;
        repeat (32) begin
            @(negedge fpga_clk);
            cnt += int'(led_out[0]);
        end
        check("pwm_zero", 32'(cnt), 32'd0);
        led_in     = '0;
        brightness = 4'd15;
        repeat (20) @(negedge fpga_clk);

        // Asynchronous reset during a hold
        cover_led_in[0] = 1'b1;
        @(negedge fpga_clk);
        cover_led_in[0] = 1'b0;
        repeat (2) @(negedge fpga_clk);
        check("pre_reset_active", 32'(cover_led_out[0]), 32'h1);
        #2 sys_init_ctrl_n = 1'b0;
        #1 check("reset_immediate", 32'({led_out, cover_led_out}), 32'h0);
        repeat (2) @(negedge fpga_clk);
        sys_init_ctrl_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge fpga_clk);
            cnt += $countones({led_out, cover_led_out});
        end
        check("post_reset_quiet", 32'(cnt), 32'd0);

        // Lamp test
`ifdef LED_LAMP_TEST_EN
        lamp_exp = 13'h1fff;
`else
        lamp_exp = 13'h0;
`endif
        brightness = 4'd0;
        lamp_test  = 1'b1;
        @(negedge fpga_clk);
        check("lamp_on", 32'({led_out, cover_led_out}), 32'(lamp_exp));
        lamp_test = 1'b0;
        @(negedge fpga_clk);
        check("lamp_off", 32'({led_out, cover_led_out}), 32'h0);
        repeat (4) @(negedge fpga_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
